minterm_sweep_unit: RTL and testbench

Sequential, parametrised truth-table function unit for N-input Boolean functions given as a minterm mask (sum-of-minterms form). The mask is loaded serially. The unit then answers single-point evaluations with one-cycle latency. It can also sweep all 2^N input combinations autonomously, streaming each minterm result and counting the on-set. It sits beside the combinational SOP function blocks as their reusable, self-checking successor: the exhaustive sweep replaces hand-written stimulus lists.

---
 rtl/minterm_pkg.sv | 14 +
 rtl/minterm_table.sv | 34 +++
 rtl/minterm_sweep_unit.sv | 148 ++++++++++++++
 tb/tb_minterm_sweep_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/minterm_pkg.sv
// Shared definitions for the minterm sweep unit: FSM states and the legal
// range of the function input count.
package minterm_pkg;

  localparam int N_MIN = 2;
  localparam int N_MAX = 6;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    READY = 2'd1,
    SWEEP = 2'd2
  } state_t;

endpackage

// File: rtl/minterm_table.sv
// K-bit truth-table storage: one indexed write port and two combinational
// read ports (point evaluation and sweep).
module minterm_table
  import minterm_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [N-1:0] wr_addr,
  input  logic         wr_bit,
  input  logic [N-1:0] eval_addr,
  output logic         eval_bit,
  input  logic [N-1:0] sweep_addr,
  output logic         sweep_bit
);

  localparam int K = 1 << N;

  logic [K-1:0] tbl;

  always_ff @(posedge clk) begin
    if (reset) begin
      tbl <= '0;
    end else if (we) begin
      tbl[wr_addr] <= wr_bit;
    end
  end

  assign eval_bit  = tbl[eval_addr];
  assign sweep_bit = tbl[sweep_addr];

endmodule

// File: rtl/minterm_sweep_unit.sv
// Truth-table function unit: serial mask load, one-cycle point evaluation and
// an autonomous sweep of all 2^N minterms that counts the on-set.
module minterm_sweep_unit
  import minterm_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_valid,
  input  logic         load_bit,
  output logic         load_ready,
  output logic         table_ok,
  input  logic         eval_valid,
  input  logic [N-1:0] eval_in,
  output logic         f,
  output logic         f_valid,
  input  logic         start,
  output logic         busy,
  output logic [N-1:0] sweep_idx,
  output logic         sweep_f,
  output logic         sweep_valid,
  output logic         done,
  output logic [N:0]   ones_count
);

  localparam int K = 1 << N;

  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("minterm_sweep_unit: N=%0d outside %0d..%0d", N, N_MIN, N_MAX);
  end

  state_t       state, state_nxt;
  logic [N-1:0] ld_cnt;
  logic [N:0]   sw_cnt;
  logic [N:0]   acc;
  logic         f_p1;
  logic         vld_p1;
  logic         done_p1;
  logic         eval_bit;
  logic         sweep_bit;

  logic         load_acc;
  logic         reload;
  logic         eval_acc;
  logic         start_acc;
  logic         last_ld;
  logic         last_beat;
  logic [N-1:0] wr_addr;

  // A load in READY always wins over eval and start presented with it.
  assign load_acc  = load_valid && (state != SWEEP);
  assign reload    = load_valid && (state == READY);
  assign eval_acc  = eval_valid && (state == READY) && !load_valid;
  assign start_acc = start && (state == READY) && !load_valid;
  assign last_ld   = load_valid && (state == LOAD) && (ld_cnt == N'(K - 1));
  assign last_beat = (state == SWEEP) && (sw_cnt == (N + 1)'(K - 1));
  assign wr_addr   = reload ? '0 : ld_cnt;

  minterm_table #(.N(N)) u_table (
    .clk        (clk),
    .reset      (reset),
    .we         (load_acc),
    .wr_addr    (wr_addr),
    .wr_bit     (load_bit),
    .eval_addr  (eval_in),
    .eval_bit   (eval_bit),
    .sweep_addr (sw_cnt[N-1:0]),
    .sweep_bit  (sweep_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (last_ld) state_nxt = READY;
      READY: begin
        if (load_valid) begin
          state_nxt = LOAD;
        end else if (start) begin
          state_nxt = SWEEP;
        end
      end
      SWEEP:   if (last_beat) state_nxt = READY;
      default: state_nxt = LOAD;
    endcase
  end

  // Stage p1: counters, accumulator and registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_cnt     <= '0;
      sw_cnt     <= '0;
      acc        <= '0;
      table_ok   <= 1'b0;
      f_p1       <= 1'b0;
      vld_p1     <= 1'b0;
      done_p1    <= 1'b0;
      ones_count <= '0;
    end else begin
      vld_p1  <= eval_acc;
      done_p1 <= last_beat;
      if (eval_acc) begin
        f_p1 <= eval_bit;
      end

      if (reload) begin
        ld_cnt   <= N'(1);
        table_ok <= 1'b0;
      end else if (load_acc) begin
        ld_cnt <= ld_cnt + N'(1);
        if (last_ld) begin
          table_ok <= 1'b1;
        end
      end

      if (start_acc) begin
        sw_cnt <= '0;
        acc    <= '0;
      end else if (state == SWEEP) begin
        acc <= acc + (N + 1)'(sweep_bit);
        if (last_beat) begin
          sw_cnt     <= '0;
          ones_count <= acc + (N + 1)'(sweep_bit);
        end else begin
          sw_cnt <= sw_cnt + (N + 1)'(1);
        end
      end
    end
  end

  assign load_ready  = (state != SWEEP);
  assign busy        = (state == SWEEP);
  assign sweep_valid = busy;
  assign sweep_idx   = busy ? sw_cnt[N-1:0] : '0;
  assign sweep_f     = busy & sweep_bit;
  assign f           = f_p1;
  assign f_valid     = vld_p1;
  assign done        = done_p1;

endmodule

// File: tb/tb_minterm_sweep_unit.sv
// Directed bench for minterm_sweep_unit: an N=4 instance for load, eval,
// sweep and corner cases, plus an N=3 instance for sweep length and full count.
module tb_minterm_sweep_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=4 instance
  logic       a_reset = 1'b1;
  logic       a_load_valid = 1'b0, a_load_bit = 1'b0;
  logic       a_eval_valid = 1'b0, a_start = 1'b0;
  logic [3:0] a_eval_in = '0;
  logic       a_load_ready, a_table_ok, a_f, a_f_valid, a_busy;
  logic [3:0] a_sweep_idx;
  logic       a_sweep_f, a_sweep_valid, a_done;
  logic [4:0] a_ones_count;

  // N=3 instance
  logic       b_reset = 1'b1;
  logic       b_load_valid = 1'b0, b_load_bit = 1'b0;
  logic       b_eval_valid = 1'b0, b_start = 1'b0;
  logic [2:0] b_eval_in = '0;
  logic       b_load_ready, b_table_ok, b_f, b_f_valid, b_busy;
  logic [2:0] b_sweep_idx;
  logic       b_sweep_f, b_sweep_valid, b_done;
  logic [3:0] b_ones_count;

  minterm_sweep_unit #(.N(4)) dut_a (
    .clk(clk), .reset(a_reset),
    .load_valid(a_load_valid), .load_bit(a_load_bit), .load_ready(a_load_ready),
    .table_ok(a_table_ok), .eval_valid(a_eval_valid), .eval_in(a_eval_in),
    .f(a_f), .f_valid(a_f_valid), .start(a_start), .busy(a_busy),
    .sweep_idx(a_sweep_idx), .sweep_f(a_sweep_f), .sweep_valid(a_sweep_valid),
    .done(a_done), .ones_count(a_ones_count)
  );

  minterm_sweep_unit #(.N(3)) dut_b (
    .clk(clk), .reset(b_reset),
    .load_valid(b_load_valid), .load_bit(b_load_bit), .load_ready(b_load_ready),
    .table_ok(b_table_ok), .eval_valid(b_eval_valid), .eval_in(b_eval_in),
    .f(b_f), .f_valid(b_f_valid), .start(b_start), .busy(b_busy),
    .sweep_idx(b_sweep_idx), .sweep_f(b_sweep_f), .sweep_valid(b_sweep_valid),
    .done(b_done), .ones_count(b_ones_count)
  );

  int n_err = 0;
  int n_checks = 0;

  typedef struct {
    logic [3:0] in;
    logic       exp_f;
  } eval_vec_t;

  eval_vec_t  ev[8];
  logic [15:0] mask_a;
  logic [7:0]  mask_b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, " load_ready"},  32'(a_load_ready), 32'd1);
    check({tag, " table_ok"},    32'(a_table_ok), 32'd0);
    check({tag, " f"},           32'(a_f), 32'd0);
    check({tag, " f_valid"},     32'(a_f_valid), 32'd0);
    check({tag, " busy"},        32'(a_busy), 32'd0);
    check({tag, " sweep_idx"},   32'(a_sweep_idx), 32'd0);
    check({tag, " sweep_f"},     32'(a_sweep_f), 32'd0);
    check({tag, " sweep_valid"}, 32'(a_sweep_valid), 32'd0);
    check({tag, " done"},        32'(a_done), 32'd0);
    check({tag, " ones_count"},  32'(a_ones_count), 32'd0);
  endtask

  initial begin
    mask_a = 16'h88CE;  // minterms 1,2,3,6,7,11,15
    mask_b = 8'hE8;     // minterms 3,5,6,7
    ev[0] = '{4'b0011, 1'b1};
    ev[1] = '{4'b1000, 1'b0};
    ev[2] = '{4'b0000, 1'b0};
    ev[3] = '{4'b0001, 1'b1};
    ev[4] = '{4'b0111, 1'b1};
    ev[5] = '{4'b1011, 1'b1};
    ev[6] = '{4'b1111, 1'b1};
    ev[7] = '{4'b1110, 1'b0};

    tick();
    tick();
    check_reset_a("reset");
    check("b reset ones_count", 32'(b_ones_count), 32'd0);
    a_reset = 1'b0;
    b_reset = 1'b0;

    // Serial load of the N=4 mask, LSB first
    for (int i = 0; i < 16; i++) begin
      a_load_valid = 1'b1;
      a_load_bit   = mask_a[i];
      tick();
      check("load load_ready", 32'(a_load_ready), 32'd1);
      check("load table_ok", 32'(a_table_ok), (i == 15) ? 32'd1 : 32'd0);
    end
    a_load_valid = 1'b0;

    // Back-to-back point evaluations from the vector table
    for (int i = 0; i < 8; i++) begin
      a_eval_valid = 1'b1;
      a_eval_in    = ev[i].in;
      tick();
      check("eval f_valid", 32'(a_f_valid), 32'd1);
      check("eval f", 32'(a_f), 32'(ev[i].exp_f));
    end
    a_eval_valid = 1'b0;
    a_eval_in    = 4'b0011;
    tick();
    check("eval idle f_valid", 32'(a_f_valid), 32'd0);
    check("eval idle f hold", 32'(a_f), 32'd0);

    // Full sweep with load/eval/start injected mid-sweep
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int idx = 0; idx < 16; idx++) begin
      check("sweep busy", 32'(a_busy), 32'd1);
      check("sweep valid", 32'(a_sweep_valid), 32'd1);
      check("sweep idx", 32'(a_sweep_idx), 32'(idx));
      check("sweep f", 32'(a_sweep_f), 32'(mask_a[idx]));
      check("sweep load_ready", 32'(a_load_ready), 32'd0);
      check("sweep f_valid", 32'(a_f_valid), 32'd0);
      check("sweep done", 32'(a_done), 32'd0);
      if (idx == 4) begin
        a_load_valid = 1'b1;
        a_load_bit   = 1'b1;
        a_eval_valid = 1'b1;
        a_start      = 1'b1;
      end
      if (idx == 7) begin
        a_load_valid = 1'b0;
        a_load_bit   = 1'b0;
        a_eval_valid = 1'b0;
        a_start      = 1'b0;
      end
      tick();
    end
    check("sweep end done", 32'(a_done), 32'd1);
    check("sweep end busy", 32'(a_busy), 32'd0);
    check("sweep end ones", 32'(a_ones_count), 32'd7);
    check("sweep end valid", 32'(a_sweep_valid), 32'd0);
    check("sweep end idx", 32'(a_sweep_idx), 32'd0);
    check("sweep end table_ok", 32'(a_table_ok), 32'd1);
    tick();
    check("post sweep done", 32'(a_done), 32'd0);
    check("post sweep ones hold", 32'(a_ones_count), 32'd7);
    check("post sweep busy", 32'(a_busy), 32'd0);

    // Load, start and eval together in READY: load wins
    a_load_valid = 1'b1;
    a_load_bit   = mask_a[0];
    a_start      = 1'b1;
    a_eval_valid = 1'b1;
    a_eval_in    = 4'b0011;
    tick();
    a_load_valid = 1'b0;
    a_start      = 1'b0;
    a_eval_valid = 1'b0;
    check("load wins busy", 32'(a_busy), 32'd0);
    check("load wins table_ok", 32'(a_table_ok), 32'd0);
    check("load wins f_valid", 32'(a_f_valid), 32'd0);
    check("load wins load_ready", 32'(a_load_ready), 32'd1);

    // Partial load (5 bits total): eval and start ignored
    for (int i = 1; i < 5; i++) begin
      a_load_valid = 1'b1;
      a_load_bit   = mask_a[i];
      tick();
    end
    a_load_valid = 1'b0;
    a_eval_valid = 1'b1;
    a_start      = 1'b1;
    tick();
    a_eval_valid = 1'b0;
    a_start      = 1'b0;
    check("partial f_valid", 32'(a_f_valid), 32'd0);
    check("partial busy", 32'(a_busy), 32'd0);
    check("partial table_ok", 32'(a_table_ok), 32'd0);
    tick();
    check("partial busy later", 32'(a_busy), 32'd0);

    for (int i = 5; i < 16; i++) begin
      a_load_valid = 1'b1;
      a_load_bit   = mask_a[i];
      tick();
    end
    a_load_valid = 1'b0;
    check("reload table_ok", 32'(a_table_ok), 32'd1);
    check("reload ones hold", 32'(a_ones_count), 32'd7);

    // Eval and start together: both served; then reset at beat 8
    a_eval_valid = 1'b1;
    a_eval_in    = 4'b0111;
    a_start      = 1'b1;
    tick();
    a_eval_valid = 1'b0;
    a_start      = 1'b0;
    check("dual f_valid", 32'(a_f_valid), 32'd1);
    check("dual f", 32'(a_f), 32'd1);
    check("dual busy", 32'(a_busy), 32'd1);
    check("dual idx0", 32'(a_sweep_idx), 32'd0);
    for (int idx = 1; idx <= 8; idx++) begin
      tick();
      check("pre-reset idx", 32'(a_sweep_idx), 32'(idx));
      check("pre-reset f", 32'(a_sweep_f), 32'(mask_a[idx]));
    end
    a_reset = 1'b1;
    tick();
    check_reset_a("midsweep reset");
    a_reset = 1'b0;
    tick();
    check("after reset done", 32'(a_done), 32'd0);
    check("after reset busy", 32'(a_busy), 32'd0);

    // N=3: load 8'hE8 and sweep
    for (int i = 0; i < 8; i++) begin
      b_load_valid = 1'b1;
      b_load_bit   = mask_b[i];
      tick();
      check("b load table_ok", 32'(b_table_ok), (i == 7) ? 32'd1 : 32'd0);
    end
    b_load_valid = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int idx = 0; idx < 8; idx++) begin
      check("b sweep idx", 32'(b_sweep_idx), 32'(idx));
      check("b sweep f", 32'(b_sweep_f), 32'(mask_b[idx]));
      check("b sweep done", 32'(b_done), 32'd0);
      tick();
    end
    check("b done", 32'(b_done), 32'd1);
    check("b busy", 32'(b_busy), 32'd0);
    check("b ones", 32'(b_ones_count), 32'd4);

    // N=3 all-ones mask: count reaches K without overflow
    for (int i = 0; i < 8; i++) begin
      b_load_valid = 1'b1;
      b_load_bit   = 1'b1;
      tick();
      if (i == 0) begin
        check("b reload table_ok", 32'(b_table_ok), 32'd0);
        check("b reload ones hold", 32'(b_ones_count), 32'd4);
      end
    end
    b_load_valid = 1'b0;
    check("b ones table_ok", 32'(b_table_ok), 32'd1);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int idx = 0; idx < 8; idx++) begin
      check("b ones sweep f", 32'(b_sweep_f), 32'd1);
      tick();
    end
    check("b all-ones done", 32'(b_done), 32'd1);
    check("b all-ones count", 32'(b_ones_count), 32'd8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
